// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: multi-channel button controller.
// Each channel synchronises and debounces its raw pin, then classifies each gesture as
// a short, double or long press. A long press on BOOT_CHANNEL latches a boot request
// that only sys_rst clears.
//
// Ports:
//   clk          system clock
//   sys_rst      synchronous active-high reset
//   btn_in       raw asynchronous button pins (N_BTN)
//   btn_level    debounced state per channel, 1 = pressed
//   short_pulse  1-cycle short-press event per channel
//   double_pulse 1-cycle double-press event per channel
//   long_pulse   1-cycle event when the long-press threshold is reached
//   held         high from the long-press threshold until release
//   boot_rst     latched boot request, active at BOOT_LOGIC_LEVEL
module btn_event_ctrl #(
    parameter int CLK_FREQUENCY      = 48000000,
    parameter int N_BTN              = 2,
    parameter int BUTTON_LOGIC_LEVEL = 1,
    parameter int DEBOUNCE_MS        = 10,
    parameter int LONG_PRESS_MS      = 1000,
    parameter int DOUBLE_GAP_MS      = 250,
    parameter int BOOT_CHANNEL       = 0,
    parameter int BOOT_LOGIC_LEVEL   = 0
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] short_pulse,
    output logic [N_BTN-1:0] double_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] held,
    output logic             boot_rst
);
    localparam int CYC_MS      = CLK_FREQUENCY / 1000;
    localparam int DEB_CYCLES  = DEBOUNCE_MS * CYC_MS;
    localparam int LONG_CYCLES = LONG_PRESS_MS * CYC_MS;
    localparam int GAP_CYCLES  = DOUBLE_GAP_MS * CYC_MS;
    localparam int MAX_CYCLES  = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int CW          = $clog2(MAX_CYCLES + 1);
    localparam int DW          = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic PRESS_LVL = BUTTON_LOGIC_LEVEL[0];
    localparam logic BOOT_LVL  = BOOT_LOGIC_LEVEL[0];

    if (LONG_CYCLES <= DEB_CYCLES) begin : g_bad_long
        $error("btn_event_ctrl: LONG_CYCLES must exceed DEB_CYCLES");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("btn_event_ctrl: DEB_CYCLES must be at least 1");
    end
    if (N_BTN < 1 || N_BTN > 8 || BOOT_CHANNEL < 0 || BOOT_CHANNEL >= N_BTN) begin : g_bad_n
        $error("btn_event_ctrl: N_BTN must be 1..8 and BOOT_CHANNEL < N_BTN");
    end

    typedef enum logic [2:0] {
        StIdle,
        StPress1,
        StWaitGap,
        StPress2,
        StLong
    } state_e;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic          sync1_q, sync2_q, pressed;
        logic [DW-1:0] deb_q, deb_d;
        logic          lvl_q, lvl_d;
        state_e        st_q, st_d;
        logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
        logic          short_q, short_d, dbl_q, dbl_d, long_q, long_d, held_q;

        assign pressed = (sync2_q == PRESS_LVL);

        // Debounce: the level only follows a mismatch that lasted DEB_CYCLES cycles.
        always_comb begin
            deb_d = '0;
            lvl_d = lvl_q;
            if (pressed != lvl_q) begin
                if (deb_q == DW'(DEB_CYCLES - 1)) begin
                    lvl_d = ~lvl_q;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
        end

        assign cnt_inc = (cnt_q == CW'(MAX_CYCLES)) ? cnt_q : cnt_q + 1'b1;

        // The FSM sees a level edge one cycle after it happens, so on entry the counter
        // already accounts for that cycle; thresholds are then measured from the edge.
        always_comb begin
            st_d    = st_q;
            cnt_d   = cnt_inc;
            short_d = 1'b0;
            dbl_d   = 1'b0;
            long_d  = 1'b0;
            unique case (st_q)
                StIdle: begin
                    cnt_d = '0;
                    if (lvl_q) begin
                        st_d  = StPress1;
                        cnt_d = CW'(1);
                    end
                end
                StPress1: begin
                    if (!lvl_q) begin
                        // Gap of 0 or 1 cycle leaves no room for a second press.
                        if (GAP_CYCLES <= 1) begin
                            short_d = 1'b1;
                            st_d    = StIdle;
                        end else begin
                            st_d  = StWaitGap;
                            cnt_d = CW'(1);
                        end
                    end else if (cnt_inc == CW'(LONG_CYCLES)) begin
                        long_d = 1'b1;
                        st_d   = StLong;
                    end
                end
                StWaitGap: begin
                    // A rise wins over a coincident timeout.
                    if (lvl_q) begin
                        st_d  = StPress2;
                        cnt_d = CW'(1);
                    end else if (cnt_inc == CW'(GAP_CYCLES)) begin
                        short_d = 1'b1;
                        st_d    = StIdle;
                    end
                end
                StPress2: begin
                    if (!lvl_q) begin
                        dbl_d = 1'b1;
                        st_d  = StIdle;
                    end else if (cnt_inc == CW'(LONG_CYCLES)) begin
                        long_d = 1'b1;
                        st_d   = StLong;
                    end
                end
                StLong: begin
                    cnt_d = '0;
                    if (!lvl_q) begin
                        st_d = StIdle;
                    end
                end
                default: begin
                    st_d  = StIdle;
                    cnt_d = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (sys_rst) begin
                sync1_q <= ~PRESS_LVL;
                sync2_q <= ~PRESS_LVL;
                deb_q   <= '0;
                lvl_q   <= 1'b0;
                st_q    <= StIdle;
                cnt_q   <= '0;
                short_q <= 1'b0;
                dbl_q   <= 1'b0;
                long_q  <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                sync1_q <= btn_in[i];
                sync2_q <= sync1_q;
                deb_q   <= deb_d;
                lvl_q   <= lvl_d;
                st_q    <= st_d;
                cnt_q   <= cnt_d;
                short_q <= short_d;
                dbl_q   <= dbl_d;
                long_q  <= long_d;
                held_q  <= (st_d == StLong);
            end
        end

        assign btn_level[i]    = lvl_q;
        assign short_pulse[i]  = short_q;
        assign double_pulse[i] = dbl_q;
        assign long_pulse[i]   = long_q;
        assign held[i]         = held_q;
    end

    // Sticky boot request; release and later presses leave it set.
    logic boot_q;

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            boot_q <= 1'b0;
        end else if (long_pulse[BOOT_CHANNEL]) begin
            boot_q <= 1'b1;
        end
    end

    assign boot_rst = boot_q ? BOOT_LVL : ~BOOT_LVL;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Self-checking bench for btn_event_ctrl: directed gestures from the test plan followed
// by randomized button activity, all checked against a timestamp-based gesture model.
module tb_btn_event_ctrl;
    localparam int NB   = 2;
    localparam int DEB  = 20;
    localparam int LONG = 100;
    localparam int GAP  = 50;
    localparam logic BOOT_LVL = 1'b0;

    localparam int PH_IDLE = 0, PH_P1 = 1, PH_GAP = 2, PH_P2 = 3, PH_LONG = 4;

    logic          clk = 1'b0;
    logic          sys_rst;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] btn_level, short_pulse, double_pulse, long_pulse, held;
    logic          boot_rst;

    btn_event_ctrl #(
        .CLK_FREQUENCY     (10000),
        .N_BTN             (NB),
        .BUTTON_LOGIC_LEVEL(1),
        .DEBOUNCE_MS       (2),
        .LONG_PRESS_MS     (10),
        .DOUBLE_GAP_MS     (5),
        .BOOT_CHANNEL      (0),
        .BOOT_LOGIC_LEVEL  (0)
    ) dut (
        .clk         (clk),
        .sys_rst     (sys_rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .short_pulse (short_pulse),
        .double_pulse(double_pulse),
        .long_pulse  (long_pulse),
        .held        (held),
        .boot_rst    (boot_rst)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state.
    logic m_d1 [NB], m_d2 [NB], m_lvl [NB];
    int   m_mis [NB], m_phase [NB], m_t0 [NB];
    logic m_short [NB], m_dbl [NB], m_long [NB], m_held [NB];
    logic m_boot;

    // Observed-event bookkeeping for the directed checks.
    int   n_short [NB], n_dbl [NB], n_long [NB], n_lvl_hi [NB];
    int   t_rise [NB], t_fall [NB], t_short [NB], t_dbl [NB], t_long [NB], t_held_fall [NB];
    int   t_boot_fall;
    logic o_lvl [NB], o_held [NB];
    logic o_boot;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NB; c++) begin
            m_d1[c] = 0; m_d2[c] = 0; m_lvl[c] = 0; m_mis[c] = 0;
            m_phase[c] = PH_IDLE; m_t0[c] = 0;
            m_short[c] = 0; m_dbl[c] = 0; m_long[c] = 0; m_held[c] = 0;
        end
        m_boot = 0;
    endtask

    // Expected register values after edge number n, given inputs sampled at that edge.
    task automatic model_edge(input int n, input logic [NB-1:0] raw, input logic rst);
        logic lp;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_long[0]) m_boot = 1;
        for (int c = 0; c < NB; c++) begin
            lp = m_lvl[c];
            // Level follows the twice-delayed pin after DEB consecutive disagreeing edges.
            if (m_d2[c] != m_lvl[c]) begin
                m_mis[c]++;
                if (m_mis[c] == DEB) begin
                    m_lvl[c] = ~m_lvl[c];
                    m_mis[c] = 0;
                end
            end else begin
                m_mis[c] = 0;
            end
            m_d2[c] = m_d1[c];
            m_d1[c] = raw[c];
            // Gesture deadlines measured from the edge time t0 of the last level change.
            m_short[c] = 0; m_dbl[c] = 0; m_long[c] = 0;
            case (m_phase[c])
                PH_IDLE: if (lp) begin m_phase[c] = PH_P1; m_t0[c] = n - 1; end
                PH_P1: begin
                    if (!lp) begin
                        if (GAP <= 1) begin m_short[c] = 1; m_phase[c] = PH_IDLE; end
                        else begin m_phase[c] = PH_GAP; m_t0[c] = n - 1; end
                    end else if (n - m_t0[c] == LONG) begin
                        m_long[c] = 1; m_phase[c] = PH_LONG;
                    end
                end
                PH_GAP: begin
                    if (lp) begin m_phase[c] = PH_P2; m_t0[c] = n - 1; end
                    else if (n - m_t0[c] == GAP) begin m_short[c] = 1; m_phase[c] = PH_IDLE; end
                end
                PH_P2: begin
                    if (!lp) begin m_dbl[c] = 1; m_phase[c] = PH_IDLE; end
                    else if (n - m_t0[c] == LONG) begin m_long[c] = 1; m_phase[c] = PH_LONG; end
                end
                default: if (!lp) m_phase[c] = PH_IDLE;
            endcase
            m_held[c] = (m_phase[c] == PH_LONG);
        end
    endtask

    task automatic clear_obs();
        for (int c = 0; c < NB; c++) begin
            n_short[c] = 0; n_dbl[c] = 0; n_long[c] = 0; n_lvl_hi[c] = 0;
            t_rise[c] = -1; t_fall[c] = -1; t_short[c] = -1; t_dbl[c] = -1;
            t_long[c] = -1; t_held_fall[c] = -1;
        end
        t_boot_fall = -1;
    endtask

    task automatic compare();
        for (int c = 0; c < NB; c++) begin
            chk($sformatf("btn_level[%0d]", c), btn_level[c], m_lvl[c]);
            chk($sformatf("short_pulse[%0d]", c), short_pulse[c], m_short[c]);
            chk($sformatf("double_pulse[%0d]", c), double_pulse[c], m_dbl[c]);
            chk($sformatf("long_pulse[%0d]", c), long_pulse[c], m_long[c]);
            chk($sformatf("held[%0d]", c), held[c], m_held[c]);
            if (btn_level[c] === 1'b1) n_lvl_hi[c]++;
            if (btn_level[c] === 1'b1 && o_lvl[c] === 1'b0) t_rise[c] = cyc;
            if (btn_level[c] === 1'b0 && o_lvl[c] === 1'b1) t_fall[c] = cyc;
            if (held[c] === 1'b0 && o_held[c] === 1'b1) t_held_fall[c] = cyc;
            if (short_pulse[c] === 1'b1) begin n_short[c]++; t_short[c] = cyc; end
            if (double_pulse[c] === 1'b1) begin n_dbl[c]++; t_dbl[c] = cyc; end
            if (long_pulse[c] === 1'b1) begin n_long[c]++; t_long[c] = cyc; end
            o_lvl[c]  = btn_level[c];
            o_held[c] = held[c];
        end
        chk("boot_rst", boot_rst, m_boot ? BOOT_LVL : ~BOOT_LVL);
        if (boot_rst === BOOT_LVL && o_boot === ~BOOT_LVL) t_boot_fall = cyc;
        o_boot = boot_rst;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge(cyc, btn_in, sys_rst);
        #1;
        compare();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_reset();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
    endtask

    int t_press, t_rst;
    int dur [NB];

    initial begin
        model_reset();
        for (int c = 0; c < NB; c++) begin o_lvl[c] = 0; o_held[c] = 0; end
        o_boot = ~BOOT_LVL;
        clear_obs();
        btn_in  = '0;
        sys_rst = 1'b1;
        run(3);
        sys_rst = 1'b0;
        run(5);

        // Bounce shorter than the debounce window is ignored.
        clear_obs();
        for (int k = 0; k < 12; k++) begin
            btn_in[0] = ~btn_in[0];
            run(5);
        end
        btn_in[0] = 1'b0;
        run(80);
        chk_int("bounce level_hi", n_lvl_hi[0], 0);
        chk_int("bounce events", n_short[0] + n_dbl[0] + n_long[0], 0);

        // Short press.
        clear_obs();
        t_press = cyc;
        btn_in[0] = 1'b1;
        run(40);
        btn_in[0] = 1'b0;
        run(150);
        chk_int("short rise latency", t_rise[0] - t_press, 22);
        chk_int("short pulse delay", t_short[0] - t_fall[0], 50);
        chk_int("short count", n_short[0], 1);
        chk_int("short other events", n_dbl[0] + n_long[0], 0);

        // Double press.
        clear_obs();
        btn_in[0] = 1'b1; run(40);
        btn_in[0] = 1'b0; run(30);
        btn_in[0] = 1'b1; run(40);
        btn_in[0] = 1'b0; run(120);
        chk_int("double count", n_dbl[0], 1);
        chk_int("double delay", t_dbl[0] - t_fall[0], 1);
        chk_int("double no short", n_short[0] + n_long[0], 0);

        // Long press latches boot.
        clear_obs();
        btn_in[0] = 1'b1; run(150);
        btn_in[0] = 1'b0; run(80);
        chk_int("long delay", t_long[0] - t_rise[0], 100);
        chk_int("held fall delay", t_held_fall[0] - t_fall[0], 1);
        chk_int("boot delay", t_boot_fall - t_long[0], 1);
        chk("boot sticky", boot_rst, BOOT_LVL);
        chk_int("long no short", n_short[0] + n_dbl[0], 0);

        // Independent channels; ch1 long press must not request boot.
        pulse_reset();
        clear_obs();
        btn_in[1] = 1'b1; run(20);
        btn_in[0] = 1'b1; run(40);
        btn_in[0] = 1'b0; run(90);
        btn_in[1] = 1'b0; run(100);
        chk_int("indep long1", n_long[1], 1);
        chk_int("indep short0", n_short[0], 1);
        chk_int("indep long0", n_long[0], 0);
        chk("indep boot idle", boot_rst, ~BOOT_LVL);

        // Reset mid-press aborts the gesture; the held button starts a new one.
        clear_obs();
        btn_in[0] = 1'b1;
        run(82);
        pulse_reset();
        t_rst = cyc;
        chk("rst level", btn_level[0], 1'b0);
        chk("rst boot", boot_rst, ~BOOT_LVL);
        run(140);
        btn_in[0] = 1'b0;
        run(60);
        chk_int("rst rerise", t_rise[0] - t_rst, 22);
        chk_int("rst long", t_long[0] - t_rise[0], 100);
        chk_int("rst no short", n_short[0] + n_dbl[0], 0);
        chk("rst boot after long", boot_rst, BOOT_LVL);

        // Randomized activity on both channels with occasional resets.
        pulse_reset();
        for (int c = 0; c < NB; c++) dur[c] = 0;
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < NB; c++) begin
                if (dur[c] == 0) begin
                    btn_in[c] = ~btn_in[c];
                    dur[c] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(15, 1))
                                                         : int'($urandom_range(180, 20));
                end
                dur[c]--;
            end
            sys_rst = ($urandom_range(700, 0) == 0);
            tick();
        end
        sys_rst = 1'b0;
        btn_in  = '0;
        run(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
